// File: rtl/dkong_wav_pkg.sv
// Shared widths, FSM encoding and cache-entry layout for the wave-ROM bridge.
// The bridge turns byte reads from the sound player into 16-bit word reads.
package dkong_wav_pkg;

    localparam int WAV_AW = 19;
    localparam int MEM_AW = 18;
    localparam int MEM_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEMAND   = 2'd1,
        ST_PREFETCH = 2'd2
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [MEM_AW-1:0] tag;
        logic [MEM_DW-1:0] data;
    } entry_t;

    // Even byte addresses live in the low lane of the memory word.
    function automatic logic [7:0] sel_byte(input logic [MEM_DW-1:0] word, input logic odd);
        return odd ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/dkong_wav_rom_bridge.sv
// Two-entry (CUR/NXT) word cache between the wave-sound player and a 16-bit memory,
// with an optional sequential prefetch of the word after CUR.
//
// Memory handshake: O_MEM_REQ is a level that rises with O_MEM_AB valid and holds both
// unchanged until the single-cycle I_MEM_ACK that returns I_MEM_DB; the request then drops
// for at least one cycle. Requests are never withdrawn, and an ACK with no request is ignored.
module dkong_wav_rom_bridge
    import dkong_wav_pkg::*;
#(
    parameter int PREFETCH_EN = 1
) (
    input  logic              I_CLK,
    input  logic              I_RSTn,
    input  logic [WAV_AW-1:0] I_ROM_AB,
    output logic [7:0]        O_ROM_DB,
    output logic              O_MEM_REQ,
    output logic [MEM_AW-1:0] O_MEM_AB,
    input  logic [MEM_DW-1:0] I_MEM_DB,
    input  logic              I_MEM_ACK,
    output logic              O_BUSY,
    output logic [1:0]        O_DBG_STATE
);

    state_t            r_state;
    state_t            w_state_nxt;
    entry_t            r_cur;
    entry_t            r_nxt;
    logic [MEM_AW-1:0] r_mem_ab;
    logic [7:0]        r_rom_db;

    logic [MEM_AW-1:0] w_tag;
    logic              w_odd;
    logic              w_cur_hit;
    logic              w_nxt_hit;
    logic              w_miss;
    logic              w_pf_start;
    logic              w_fill_hit;

    assign w_tag      = I_ROM_AB[WAV_AW-1:1];
    assign w_odd      = I_ROM_AB[0];
    assign w_cur_hit  = r_cur.valid && (r_cur.tag == w_tag);
    assign w_nxt_hit  = r_nxt.valid && (r_nxt.tag == w_tag);
    assign w_miss     = !w_cur_hit && !w_nxt_hit;
    // Prefetch only while the player sits in CUR and NXT is free to receive a word.
    assign w_pf_start = (PREFETCH_EN != 0) && w_cur_hit && !r_nxt.valid;
    assign w_fill_hit = (w_tag == r_mem_ab);

    always_ff @(posedge I_CLK) begin
        if (!I_RSTn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Every fetch returns to IDLE, so a miss raised mid-fetch is re-evaluated there.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_miss) begin
                    w_state_nxt = ST_DEMAND;
                end else if (w_pf_start) begin
                    w_state_nxt = ST_PREFETCH;
                end
            end
            ST_DEMAND, ST_PREFETCH: begin
                if (I_MEM_ACK) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        O_MEM_REQ   = (r_state == ST_DEMAND) || (r_state == ST_PREFETCH);
        O_BUSY      = (r_state == ST_DEMAND) || (r_state == ST_PREFETCH);
        O_DBG_STATE = r_state;
    end

    assign O_MEM_AB = r_mem_ab;
    assign O_ROM_DB = r_rom_db;

    always_ff @(posedge I_CLK) begin
        if (!I_RSTn) begin
            r_cur    <= '0;
            r_nxt    <= '0;
            r_mem_ab <= '0;
            r_rom_db <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cur_hit) begin
                        r_rom_db <= sel_byte(r_cur.data, w_odd);
                        if (w_pf_start) begin
                            r_mem_ab <= r_cur.tag + MEM_AW'(1);
                        end
                    end else if (w_nxt_hit) begin
                        r_cur       <= r_nxt;
                        r_nxt.valid <= 1'b0;
                        r_rom_db    <= sel_byte(r_nxt.data, w_odd);
                    end else begin
                        r_mem_ab <= w_tag;
                    end
                end
                ST_DEMAND: begin
                    // The player may have moved on; the word still fills CUR but is only shown if wanted.
                    if (I_MEM_ACK) begin
                        r_cur <= '{valid: 1'b1, tag: r_mem_ab, data: I_MEM_DB};
                    end
                    if (I_MEM_ACK && w_fill_hit) begin
                        r_rom_db <= sel_byte(I_MEM_DB, w_odd);
                    end else if (w_cur_hit) begin
                        r_rom_db <= sel_byte(r_cur.data, w_odd);
                    end
                end
                ST_PREFETCH: begin
                    if (w_cur_hit) begin
                        r_rom_db <= sel_byte(r_cur.data, w_odd);
                    end
                    if (I_MEM_ACK) begin
                        r_nxt <= '{valid: 1'b1, tag: r_mem_ab, data: I_MEM_DB};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
